// File: rtl/div32x32_fsm_dp.sv
// div32x32_fsm_dp: sequential unsigned 32/32 restoring divider, one quotient bit per clock
// Ports:
//   i_clk, i_reset (sync, active-high), i_start (sampled in idle), i_a dividend, i_b divisor
//   o_busy (division in progress), o_done (one-cycle result-valid pulse)
//   o_quotient, o_remainder, o_div_by_zero (held until the next completed division)
module div32x32_fsm_dp (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder,
  output logic        o_div_by_zero
);
  typedef enum logic {IDLE_ST, DIV_ST} state_t;
  state_t      r_state, w_state_nx;
  logic [31:0] r_rem, r_q, r_d, r_quot, r_remo;
  logic [4:0]  r_cnt;
  logic        r_z, r_busy, r_done, r_dbz;
  logic [32:0] w_shift, w_t;
  logic [31:0] w_rem_nx, w_q_nx;
  logic        w_accept, w_last;
  // The working remainder always stays below the divisor, so 32 bits hold it;
  // only the shifted trial value needs the 33rd bit.
  always_comb begin
    w_shift    = {r_rem, r_q[31]};
    w_t        = w_shift - {1'b0, r_d};
    w_rem_nx   = w_t[32] ? w_shift[31:0] : w_t[31:0];
    w_q_nx     = {r_q[30:0], ~w_t[32]};
    w_accept   = (r_state == IDLE_ST) && i_start;
    w_last     = (r_state == DIV_ST) && (r_cnt == 5'd0);
    w_state_nx = w_accept ? DIV_ST : w_last ? IDLE_ST : r_state;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE_ST;
    else         r_state <= w_state_nx;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rem  <= '0;
      r_q    <= '0;
      r_d    <= '0;
      r_z    <= 1'b0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_quot <= '0;
      r_remo <= '0;
      r_dbz  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_rem  <= '0;
        r_q    <= i_a;
        r_d    <= i_b;
        r_z    <= (i_b == 32'd0);
        r_cnt  <= 5'd31;
        r_busy <= 1'b1;
      end else if (r_state == DIV_ST) begin
        r_rem <= w_rem_nx;
        r_q   <= w_q_nx;
        r_cnt <= r_cnt - 5'd1;
        if (w_last) begin
          r_busy <= 1'b0;
          r_quot <= w_q_nx;
          r_remo <= w_rem_nx;
          r_dbz  <= r_z;
        end
      end
    end
  end
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_quotient    = r_quot;
  assign o_remainder   = r_remo;
  assign o_div_by_zero = r_dbz;
endmodule

// File: tb/tb_div32x32_fsm_dp.sv
// tb_div32x32_fsm_dp: table-driven, scoreboarded bench for div32x32_fsm_dp
module tb_div32x32_fsm_dp;
  logic        clk, rst, start, busy, done, dbz;
  logic [31:0] a, b, quo, rem;
  int n_checks = 0;
  int n_fail = 0;
  typedef struct {logic [31:0] a, b, q, r; logic z;} vec_t;
  typedef struct {logic [31:0] q, r; logic z;} exp_t;
  exp_t sb[$];
  vec_t tbl[9];

  div32x32_fsm_dp dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_a(a), .i_b(b),
    .o_busy(busy), .o_done(done), .o_quotient(quo), .o_remainder(rem),
    .o_div_by_zero(dbz)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every done pulse pops one expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quo, e.q);
        chk("remainder", rem, e.r);
        chk("div_by_zero", {31'd0, dbz}, {31'd0, e.z});
        chk("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    e.q = (y == 0) ? 32'hFFFF_FFFF : x / y;
    e.r = (y == 0) ? x : x % y;
    e.z = (y == 0);
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic start_div(input logic [31:0] x, input logic [31:0] y, input exp_t e, input logic hold);
    start = 1; a = x; b = y;
    sb.push_back(e);
    @(negedge clk);
    if (!hold) start = 0;
    a = $urandom; b = $urandom;
  endtask

  // Returns at the negedge of the done cycle (or after the timeout).
  task automatic wait_done;
    int n;
    bit seen;
    n = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1;
      else begin
        if (busy) n++;
        @(negedge clk);
      end
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("busy_cycles", n, 32'd32);
  endtask

  initial begin
    exp_t e;
    tbl[0] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    tbl[1] = '{32'd3, 32'd10, 32'd0, 32'd3, 1'b0};
    tbl[2] = '{32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0};
    tbl[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0};
    tbl[4] = '{32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1};
    tbl[5] = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0};
    tbl[6] = '{32'h8000_0000, 32'd3, 32'd715827882, 32'd2, 1'b0};
    tbl[7] = '{32'd1234567890, 32'd12345, 32'd100005, 32'd6165, 1'b0};
    tbl[8] = '{32'd7, 32'd7, 32'd1, 32'd0, 1'b0};
    rst = 1; start = 0; a = 0; b = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_quotient", quo, 32'd0);
    chk("rst_remainder", rem, 32'd0);
    chk("rst_dbz", {31'd0, dbz}, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      e.q = tbl[i].q; e.r = tbl[i].r; e.z = tbl[i].z;
      start_div(tbl[i].a, tbl[i].b, e, 1'b0);
      wait_done();
      @(negedge clk);
      chk("done_cleared", {31'd0, done}, 32'd0);
      chk("quotient_held", quo, tbl[i].q);
      chk("remainder_held", rem, tbl[i].r);
    end
    // Start held high throughout, then back-to-back accept in the done cycle.
    start_div(32'd1000, 32'd9, model(32'd1000, 32'd9), 1'b1);
    chk("model_1000_9_q", 32'd111, model(32'd1000, 32'd9).q);
    wait_done();
    a = 32'd20; b = 32'd4;
    e.q = 32'd5; e.r = 32'd0; e.z = 1'b0;
    start_div(a, b, e, 1'b0);
    wait_done();
    @(negedge clk);
    // Reset during iteration 10.
    e.q = 32'd14; e.r = 32'd2; e.z = 1'b0;
    start_div(32'd100, 32'd7, e, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    sb.delete();
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_quotient", quo, 32'd0);
    chk("midrst_remainder", rem, 32'd0);
    begin
      int dn;
      dn = 0;
      repeat (40) begin
        if (done) dn++;
        @(negedge clk);
      end
      chk("midrst_no_done", dn, 32'd0);
    end
    start_div(32'd100, 32'd7, model(32'd100, 32'd7), 1'b0);
    wait_done();
    @(negedge clk);
    // Reset and start together: reset wins.
    rst = 1; start = 1; a = 32'd9; b = 32'd3;
    @(negedge clk);
    rst = 0; start = 0;
    chk("rst_start_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_start_idle", {31'd0, busy}, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
